// File: rtl/weight_memory_nbank_if.sv
// Weight-memory bus: external write port, tiled read request/response and status.
interface weight_memory_nbank_if #(
    parameter int N_DIM_ARRAY             = 4,
    parameter int WEIGHT_DATA_WIDTH       = 8,
    parameter int N_BANKS                 = 2,
    parameter int BANK_WORDS              = 2048,
    parameter int WEIGHT_MEMORY_ADDR_SIZE = $clog2(N_BANKS * BANK_WORDS)
);
    localparam int LANE_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
    localparam int TILE_W = N_DIM_ARRAY * LANE_W;

    logic                               wr_en;
    logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] wr_addr;
    logic [LANE_W-1:0]                  wr_data;
    logic                               rd_req;
    logic                               rd_gnt;
    logic [2:0]                         mode;
    logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] rd_addr;
    logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] weight_memory_pointer;
    logic                               rd_valid;
    logic [TILE_W-1:0]                  read_word;
    logic [15:0]                        collision_cnt;
    logic                               mode_err;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, mode, rd_addr, weight_memory_pointer,
        input  rd_gnt, rd_valid, read_word, collision_cnt, mode_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, mode, rd_addr, weight_memory_pointer,
        output rd_gnt, rd_valid, read_word, collision_cnt, mode_err
    );
endinterface

// File: rtl/weight_memory_nbank.sv
// Banked weight store: each bank is split into N lane-interleaved columns so an
// FC tile (N consecutive lanes) is one row across all columns of a single bank.
module weight_lane_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

module weight_memory_nbank #(
    parameter int N_DIM_ARRAY             = 4,
    parameter int WEIGHT_DATA_WIDTH       = 8,
    parameter int N_BANKS                 = 2,
    parameter int BANK_WORDS              = 2048,
    parameter int WEIGHT_MEMORY_ADDR_SIZE = $clog2(N_BANKS * BANK_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    weight_memory_nbank_if.slave  bus
);
    localparam int N      = N_DIM_ARRAY;
    localparam int A      = WEIGHT_MEMORY_ADDR_SIZE;
    localparam int LOG2N  = $clog2(N);
    localparam int BB     = $clog2(N_BANKS);
    localparam int BWB    = $clog2(BANK_WORDS);
    localparam int RW     = BWB - LOG2N;
    localparam int ROWS   = BANK_WORDS / N;
    localparam int LANE_W = N * WEIGHT_DATA_WIDTH;
    localparam int TILE_W = N * LANE_W;

    logic [BB-1:0]    wr_bank;
    logic [RW-1:0]    wr_row;
    logic [LOG2N-1:0] wr_col;

    logic [A-1:0]     eff;
    logic [A-1:0]     rd_lane;
    logic [BB-1:0]    rd_bank;
    logic [RW-1:0]    rd_row;
    logic [LOG2N-1:0] rd_col;

    logic mode_fc, mode_legal, conflict, rd_gnt_c, stall;

    logic [LANE_W-1:0] ram_rd  [N_BANKS][N];
    logic [LANE_W-1:0] bank_rd [N];
    logic [N-1:0][LANE_W-1:0] tile;

    logic              rd_valid_q;
    logic [TILE_W-1:0] read_word_q;
    logic [15:0]       collision_q;
    logic              mode_err_q;

    assign wr_bank = bus.wr_addr[A-1 -: BB];
    assign wr_row  = bus.wr_addr[BWB-1:LOG2N];
    assign wr_col  = bus.wr_addr[LOG2N-1:0];

    // Carry out of the add is dropped so the pointer wraps around the address space.
    assign eff        = bus.rd_addr + bus.weight_memory_pointer;
    assign mode_fc    = (bus.mode == 3'd0);
    assign mode_legal = (bus.mode == 3'd0) || (bus.mode == 3'd1);
    assign rd_lane    = mode_fc ? {eff[A-1:LOG2N], {LOG2N{1'b0}}} : eff;
    assign rd_bank    = rd_lane[A-1 -: BB];
    assign rd_row     = rd_lane[BWB-1:LOG2N];
    assign rd_col     = rd_lane[LOG2N-1:0];

    // Same-bank write wins; the read waits so it never sees a half-updated tile.
    assign conflict = bus.wr_en && (wr_bank == rd_bank);
    assign rd_gnt_c = bus.rd_req && mode_legal && !conflict;
    assign stall    = bus.rd_req && mode_legal && conflict;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        for (genvar c = 0; c < N; c++) begin : g_col
            logic hit;
            assign hit = bus.wr_en && (wr_bank == BB'(b)) && (wr_col == LOG2N'(c));

            weight_lane_ram #(.DEPTH(ROWS), .AW(RW), .DW(LANE_W)) u_ram (
                .clk   (clk),
                .we    (hit),
                .waddr (wr_row),
                .wdata (bus.wr_data),
                .raddr (rd_row),
                .rdata (ram_rd[b][c])
            );
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) bank_rd[c] = ram_rd[rd_bank][c];
    end

    // FC: column i feeds row i. CNN: only the addressed column, into row 0.
    always_comb begin
        tile = '0;
        for (int i = 0; i < N; i++) tile[i] = mode_fc ? bank_rd[i] : '0;
        if (!mode_fc) tile[0] = bank_rd[rd_col];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid_q  <= 1'b0;
            read_word_q <= '0;
            collision_q <= '0;
            mode_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_gnt_c;
            if (rd_gnt_c) read_word_q <= tile;
            if (stall && (collision_q != 16'hFFFF)) collision_q <= collision_q + 16'd1;
            if (bus.rd_req && !mode_legal) mode_err_q <= 1'b1;
        end
    end

    assign bus.rd_gnt        = rd_gnt_c;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.read_word     = read_word_q;
    assign bus.collision_cnt = collision_q;
    assign bus.mode_err      = mode_err_q;
endmodule

// File: tb/tb_weight_memory_nbank.sv
// Randomised and directed checks of weight_memory_nbank against a flat-array lane model.
module tb_weight_memory_nbank;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    weight_memory_nbank_if bus ();
    weight_memory_nbank dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0]  mem_m [4096];
    logic         exp_valid;
    logic [127:0] exp_word;
    int           exp_cnt;
    logic         exp_err;
    logic         obs_gnt, exp_gnt;

    function automatic logic [127:0] model_tile(int md, int ra, int ptr);
        logic [127:0] t = '0;
        int eff = (ra + ptr) % 4096;
        if (md == 1) t[31:0] = mem_m[eff];
        else begin
            int base = eff - (eff % 4);
            for (int i = 0; i < 4; i++) t[i*32 +: 32] = mem_m[base + i];
        end
        return t;
    endfunction

    task automatic cycle(input bit r, input bit we, input logic [11:0] wa, input logic [31:0] wd,
                         input bit rq, input logic [2:0] md, input logic [11:0] ra, input logic [11:0] ptr);
        int eff;
        bit legal, confl;
        logic [127:0] t;
        @(negedge clk);
        reset = r; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.rd_req = rq; bus.mode = md; bus.rd_addr = ra; bus.weight_memory_pointer = ptr;
        #1;
        obs_gnt = bus.rd_gnt;
        eff     = (int'(ra) + int'(ptr)) % 4096;
        legal   = (md < 2);
        confl   = we && ((int'(wa) / 2048) == (eff / 2048));
        exp_gnt = rq && legal && !confl;
        t       = model_tile(int'(md), int'(ra), int'(ptr));
        @(posedge clk);
        if (!r) begin
            exp_valid = 0; exp_word = '0; exp_cnt = 0; exp_err = 0;
        end else begin
            exp_valid = exp_gnt;
            if (exp_gnt) exp_word = t;
            if (rq && legal && confl && exp_cnt < 65535) exp_cnt++;
            if (rq && !legal) exp_err = 1;
        end
        if (we) mem_m[wa] = wd;
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 4096; i++) cycle(1, 1, 12'(i), $urandom, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 1, 1, 12'd7, 0);
        cycle(0, 1, 12'd100, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.read_word !== 128'd0) begin errors++; $display("FAIL reset_word got=%h exp=0", bus.read_word); end
        checks++; if (bus.collision_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.collision_cnt); end
        checks++; if (bus.mode_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.mode_err); end
        cycle(1, 0, 0, 0, 1, 1, 12'd100, 0);
        checks++; if (bus.read_word !== {96'd0, 32'hDEADBEEF}) begin errors++; $display("FAIL write_in_reset got=%h exp=deadbeef", bus.read_word); end
    endtask

    task automatic test_cnn();
        cycle(1, 1, 12'd5, 32'h04030201, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 12'd2, 12'd3);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL cnn_gnt got=%b exp=1", obs_gnt); end
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL cnn_valid got=%b exp=1", bus.rd_valid); end
        checks++; if (bus.read_word !== {96'd0, 32'h04030201}) begin errors++; $display("FAIL cnn_word got=%h exp=04030201", bus.read_word); end
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL cnn_valid_pulse got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.read_word !== {96'd0, 32'h04030201}) begin errors++; $display("FAIL cnn_hold got=%h exp=04030201", bus.read_word); end
    endtask

    task automatic test_fc();
        for (int i = 0; i < 4; i++) cycle(1, 1, 12'(8 + i), {4{8'(8'hA0 + i)}}, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 12'd10, 0);
        checks++; if (bus.read_word !== 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0) begin
            errors++; $display("FAIL fc_tile got=%h exp=a3a3a3a3a2a2a2a2a1a1a1a1a0a0a0a0", bus.read_word); end
    endtask

    task automatic test_wrap();
        cycle(1, 1, 12'd1, 32'h5A5A1234, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 1, 12'd2, 12'hFFF);
        checks++; if (bus.read_word !== {96'd0, 32'h5A5A1234}) begin errors++; $display("FAIL wrap_word got=%h exp=5a5a1234", bus.read_word); end
    endtask

    task automatic test_collision();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 12'(16 + k), $urandom, 1, 1, 12'h020, 0);
            checks++; if (obs_gnt !== 1'b0) begin errors++; $display("FAIL coll_stall%0d got=%b exp=0", k, obs_gnt); end
        end
        checks++; if (bus.collision_cnt !== 16'd3) begin errors++; $display("FAIL coll_cnt got=%0d exp=3", bus.collision_cnt); end
        cycle(1, 0, 0, 0, 1, 1, 12'h020, 0);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL coll_grant4 got=%b exp=1", obs_gnt); end
        checks++; if (bus.read_word !== exp_word) begin errors++; $display("FAIL coll_word got=%h exp=%h", bus.read_word, exp_word); end
        cycle(1, 1, 12'h005, $urandom, 1, 1, 12'h900, 0);
        checks++; if (obs_gnt !== 1'b1) begin errors++; $display("FAIL coll_other_bank got=%b exp=1", obs_gnt); end
        checks++; if (bus.read_word !== exp_word) begin errors++; $display("FAIL coll_other_word got=%h exp=%h", bus.read_word, exp_word); end
        checks++; if (bus.collision_cnt !== 16'd3) begin errors++; $display("FAIL coll_cnt_hold got=%0d exp=3", bus.collision_cnt); end
    endtask

    task automatic test_abandon();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 12'd0, $urandom, 1, 1, 12'd1, 0);
        cycle(1, 1, 12'd2, $urandom, 0, 1, 12'd1, 0);
        checks++; if (bus.collision_cnt !== 16'd1) begin errors++; $display("FAIL abandon_cnt got=%0d exp=1", bus.collision_cnt); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL abandon_valid got=%b exp=0", bus.rd_valid); end
    endtask

    task automatic test_mode_err();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 3'd5, 12'd4, 0);
        checks++; if (obs_gnt !== 1'b0) begin errors++; $display("FAIL moderr_gnt got=%b exp=0", obs_gnt); end
        checks++; if (bus.mode_err !== 1'b1) begin errors++; $display("FAIL moderr_set got=%b exp=1", bus.mode_err); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL moderr_valid got=%b exp=0", bus.rd_valid); end
        cycle(1, 0, 0, 0, 1, 3'd0, 12'd4, 0);
        checks++; if (bus.mode_err !== 1'b1) begin errors++; $display("FAIL moderr_sticky got=%b exp=1", bus.mode_err); end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (bus.mode_err !== 1'b0) begin errors++; $display("FAIL moderr_clear got=%b exp=0", bus.mode_err); end
    endtask

    task automatic test_reset_mid_read();
        cycle(1, 0, 0, 0, 1, 1, 12'd5, 0);
        cycle(0, 0, 0, 0, 1, 1, 12'd5, 0);
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", bus.rd_valid); end
        checks++; if (bus.read_word !== 128'd0) begin errors++; $display("FAIL rst_mid_word got=%h exp=0", bus.read_word); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [11:0] ra = 12'($urandom), ptr = 12'($urandom), wa = 12'($urandom);
            logic [2:0]  md = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            bit r  = ($urandom_range(0, 29) != 0);
            bit we = $urandom_range(0, 1);
            bit rq = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 2) == 0) wa[11] = ra[11] ^ ptr[11] ^ ((ra[10:0] + ptr[10:0]) > 12'h7FF);
            cycle(r, we, wa, $urandom, rq, md, ra, ptr);
            checks++; if (obs_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt n=%0d got=%b exp=%b", n, obs_gnt, exp_gnt); end
            checks++; if (bus.rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.rd_valid, exp_valid); end
            checks++; if (bus.read_word !== exp_word) begin errors++; $display("FAIL rnd_word n=%0d got=%h exp=%h", n, bus.read_word, exp_word); end
            checks++; if (bus.collision_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, bus.collision_cnt, exp_cnt); end
            checks++; if (bus.mode_err !== exp_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, bus.mode_err, exp_err); end
        end
    endtask

    initial begin
        reset = 1'b0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_req = 0; bus.mode = 0; bus.rd_addr = 0; bus.weight_memory_pointer = 0;
        exp_valid = 0; exp_word = '0; exp_cnt = 0; exp_err = 0;
        preload();
        test_reset();
        test_cnn();
        test_fc();
        test_wrap();
        test_collision();
        test_abandon();
        test_mode_err();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/weight_memory_nbank.md
WEIGHT_MEMORY_NBANK -- requirements
Module: weight_memory_nbank

Interface
REQ-001: Parameter N_DIM_ARRAY, default 4, PE array dimension N; power of 2, at least 2; LOG2N = log2(N).
REQ-002: Parameter WEIGHT_DATA_WIDTH, default 8, width W of one weight.
REQ-003: Parameter N_BANKS, default 2, number of weight banks; power of 2, at least 2.
REQ-004: Parameter BANK_WORDS, default 2048, lane words per bank; power of 2, multiple of N.
REQ-005: Parameter WEIGHT_MEMORY_ADDR_SIZE, default log2(N_BANKS*BANK_WORDS), lane-word address width A.
REQ-006: clk  input  1  single clock; all state updates on rising edge.
REQ-007: reset  input  1  synchronous, active-low reset.
REQ-008: wr_en  input  1  external weight write strobe.
REQ-009: wr_addr  input  A  lane-word write address.
REQ-010: wr_data  input  N*W  lane word to write.
REQ-011: rd_req  input  1  read request; held until granted.
REQ-012: rd_gnt  output  1  read accepted this cycle (combinational).
REQ-013: mode  input  3  0 = FC, 1 = CNN, other values illegal.
REQ-014: rd_addr  input  A  read offset.
REQ-015: weight_memory_pointer  input  A  layer base pointer.
REQ-016: rd_valid  output  1  read_word updated this cycle.
REQ-017: read_word  output  N*N*W  weight tile; element (i,j) at bit offset (i*N+j)*W.
REQ-018: collision_cnt  output  16  saturating count of stalled read cycles.
REQ-019: mode_err  output  1  sticky illegal-mode flag.

Function
REQ-020: Storage SHALL be N_BANKS arrays of BANK_WORDS lane words; the bank index is the top log2(N_BANKS) bits of the lane address; contents are not reset.
REQ-021: A write SHALL store wr_data at wr_addr on the clock edge where wr_en=1; writes are never stalled.
REQ-022: The effective address SHALL be eff = (rd_addr + weight_memory_pointer) mod 2^A, with carry discarded (wrap-around).
REQ-023: In CNN mode, lane address L = eff; one lane word is read into row 0 of read_word, and rows 1..N-1 are zero.
REQ-024: In FC mode, L = eff with its low LOG2N bits cleared; lanes L..L+N-1 (same bank) are read; lane L+i is placed into row i.
REQ-025: rd_gnt SHALL equal rd_req AND (mode in {0,1}) AND NOT (wr_en AND write bank == read bank).
REQ-026: Reads and writes to different banks SHALL both proceed in the same cycle.
REQ-027: For a granted read, read_word SHALL be updated and rd_valid asserted for exactly one cycle on the next edge (latency 1).
REQ-028: read_word SHALL hold its value until the next granted read.
REQ-029: A read never returns partially written data, because same-bank overlap is stalled by REQ-025.
REQ-030: collision_cnt SHALL increment by 1 for each cycle with rd_req=1, a legal mode, and a bank conflict; it saturates at 0xFFFF.
REQ-031: mode_err SHALL be set on any cycle with rd_req=1 and mode not in {0,1}, and cleared only by reset; no read is granted in that cycle.
REQ-032: If the requester drops rd_req before a grant, the request is abandoned with no side effects.

Reset
REQ-033: When reset=0 at a clock edge, the next state SHALL be rd_valid=0, read_word=0, collision_cnt=0, mode_err=0.
REQ-034: A read granted in the same cycle reset is low SHALL be discarded; rd_valid stays 0 in the following cycle.
REQ-035: A write with wr_en=1 during reset SHALL still update memory; reset does not gate writes.

Verification
REQ-036: CNN read: write 0x04030201 at lane 5, then pointer=3, rd_addr=2, mode=1 -> next cycle rd_valid=1, read_word[31:0]=0x04030201, upper bits 0.
REQ-037: FC read: lanes 8..11 hold 0xA0..A3 replicated in each byte, mode=0, eff=10 -> rows 0..3 = lanes 8..11 in order.
REQ-038: Wrap: pointer=0xFFF, rd_addr=2 with A=12 -> eff=1, lane 1 data returned.
REQ-039: Collision: wr_en to bank 0 for 3 cycles while rd_req targets bank 0 -> rd_gnt=0 for 3 cycles, collision_cnt=3, grant on the 4th cycle; a read to bank 1 during the writes is granted immediately.
REQ-040: mode=5 with rd_req=1 -> rd_gnt=0, mode_err=1 persists after mode returns to 0, cleared only by reset.
REQ-041: Reset mid-read: assert reset in the grant cycle -> rd_valid=0 and read_word=0 on the following cycle.
